// File: rtl/mod_div_pkg.sv
// Shared types and helpers for the signed iterative divider.
// Holds the FSM encoding and a conditional two's-complement negate.
package mod_div_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int MAX_W     = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Callers zero-extend into MAX_W and truncate back to their width, so
   // the low bits form a correct negate (or magnitude) at any width.
   function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                  input logic             neg);
      logic [MAX_W-1:0] r;
      if (neg) begin
         r = ~v + 64'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/mod_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// conditionally subtract the divisor magnitude.
module mod_div_step
   import mod_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] diff_s;

   // The remainder is always below the divisor, so its MSB is zero and the
   // shifted value fits in WIDTH+1 bits; diff_s[WIDTH] is the borrow.
   always_comb begin
      diff_s = {rem, bit_in} - {1'b0, divisor};
      q_bit  = ~diff_s[WIDTH];
      if (q_bit) begin
         rem_next = diff_s[WIDTH-1:0];
      end else begin
         rem_next = {rem[WIDTH-2:0], bit_in};
      end
   end

endmodule

// File: rtl/mod_div.sv
// Signed iterative divider: magnitudes are divided one quotient bit per
// clock, then signs are reapplied in a single fix-up cycle.
module mod_div
   import mod_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resultado,
   output logic [WIDTH-1:0] resto,
   output logic             flag_overflow,
   output logic             flag_div_zero
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MINUS_1  = {WIDTH{1'b1}};

   state_t           state_r, state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] rem_r, dvd_r, dvs_r;
   logic             sign_q_r, sign_r_r, ovf_r;
   logic             busy_r, done_r, flag_ovf_r, flag_dz_r;
   logic [WIDTH-1:0] resultado_r, resto_r;
   logic             accept_s, b_zero_s, q_bit_s, busy_s, done_s;
   logic [WIDTH-1:0] rem_next_s;

   assign accept_s = (state_r == ST_IDLE) && start;
   assign b_zero_s = (b == {WIDTH{1'b0}});

   mod_div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_r),
      .bit_in   (dvd_r[WIDTH-1]),
      .divisor  (dvs_r),
      .rem_next (rem_next_s),
      .q_bit    (q_bit_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = b_zero_s ? ST_DONE : ST_CALC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_r == CNT_LAST) begin
               state_next_s = ST_FIX;
            end else begin
               state_next_s = ST_CALC;
            end
         end
         ST_FIX:  state_next_s = ST_DONE;
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Handshake decode from the upcoming state so busy/done can be registered
   always_comb begin
      busy_s = (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
      done_s = (state_next_s == ST_DONE);
   end

   // Operand capture, iteration, sign fix-up and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= {CNT_W{1'b0}};
         rem_r       <= {WIDTH{1'b0}};
         dvd_r       <= {WIDTH{1'b0}};
         dvs_r       <= {WIDTH{1'b0}};
         sign_q_r    <= 1'b0;
         sign_r_r    <= 1'b0;
         ovf_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         resultado_r <= {WIDTH{1'b0}};
         resto_r     <= {WIDTH{1'b0}};
         flag_ovf_r  <= 1'b0;
         flag_dz_r   <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s && b_zero_s) begin
                  resultado_r <= {WIDTH{1'b0}};
                  resto_r     <= a;
                  flag_dz_r   <= 1'b1;
                  flag_ovf_r  <= 1'b0;
               end else if (accept_s) begin
                  dvd_r    <= WIDTH'(cond_neg(MAX_W'(a), a[WIDTH-1]));
                  dvs_r    <= WIDTH'(cond_neg(MAX_W'(b), b[WIDTH-1]));
                  rem_r    <= {WIDTH{1'b0}};
                  cnt_r    <= {CNT_W{1'b0}};
                  sign_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
                  sign_r_r <= a[WIDTH-1];
                  ovf_r    <= (a == MOST_NEG) && (b == MINUS_1);
               end
            end
            ST_CALC: begin
               rem_r <= rem_next_s;
               dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
               cnt_r <= cnt_r + CNT_W'(1);
            end
            ST_FIX: begin
               // MOST_NEG / -1 yields magnitude 2^(WIDTH-1), which already wraps to MOST_NEG
               resultado_r <= WIDTH'(cond_neg(MAX_W'(dvd_r), sign_q_r));
               resto_r     <= WIDTH'(cond_neg(MAX_W'(rem_r), sign_r_r));
               flag_ovf_r  <= ovf_r;
               flag_dz_r   <= 1'b0;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign resultado     = resultado_r;
   assign resto         = resto_r;
   assign flag_overflow = flag_ovf_r;
   assign flag_div_zero = flag_dz_r;

endmodule

// File: tb/tb_mod_div.sv
// Directed self-checking bench for mod_div (WIDTH=8), one task per scenario.
module tb_mod_div;

   logic       clk, rst_n, start;
   logic [7:0] a, b;
   logic       busy, done, flag_overflow, flag_div_zero;
   logic [7:0] resultado, resto;
   int         errors = 0;
   int         checks = 0;

   mod_div #(.WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .a             (a),
      .b             (b),
      .busy          (busy),
      .done          (done),
      .resultado     (resultado),
      .resto         (resto),
      .flag_overflow (flag_overflow),
      .flag_div_zero (flag_div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Called 1 time unit after a posedge; leaves a possible DONE cycle, then
   // issues one request. lat counts edges from the sampling edge (=1) to done.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int busy_cnt);
      @(posedge clk); #1;
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      busy_cnt = 0;
      for (int e = 1; e <= 40; e++) begin
         if (done === 1'b1) begin
            lat = e;
            break;
         end
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL reset_resultado: got %h want 00", resultado); end
      checks++; if (resto !== 8'h00) begin errors++; $display("FAIL reset_resto: got %h want 00", resto); end
      checks++; if (flag_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", flag_overflow); end
      checks++; if (flag_div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", flag_div_zero); end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_positive();
      int lat, bc;
      do_op(8'd100, 8'd7, lat, bc);
      checks++; if (lat !== 10) begin errors++; $display("FAIL pos_latency: got %0d want 10", lat); end
      checks++; if (bc !== 9) begin errors++; $display("FAIL pos_busy_cycles: got %0d want 9", bc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pos_busy_at_done: got %b want 0", busy); end
      checks++; if (resultado !== 8'd14) begin errors++; $display("FAIL pos_resultado: got %h want 0e", resultado); end
      checks++; if (resto !== 8'd2) begin errors++; $display("FAIL pos_resto: got %h want 02", resto); end
      checks++; if ({flag_overflow, flag_div_zero} !== 2'b00) begin errors++; $display("FAIL pos_flags: got %b want 00", {flag_overflow, flag_div_zero}); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL pos_done_pulse: got %b want 0", done); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({resultado, resto} !== {8'd14, 8'd2}) begin errors++; $display("FAIL pos_hold: got %h want 0e02", {resultado, resto}); end
   endtask

   task automatic test_signs();
      logic [7:0] ta [3] = '{8'h9C, 8'd100, 8'h9C};
      logic [7:0] tb [3] = '{8'd7,  8'hF9,  8'hF9};
      logic [7:0] tq [3] = '{8'hF2, 8'hF2,  8'd14};
      logic [7:0] tr [3] = '{8'hFE, 8'd2,   8'hFE};
      int lat, bc;
      for (int i = 0; i < 3; i++) begin
         do_op(ta[i], tb[i], lat, bc);
         checks++; if (lat !== 10) begin errors++; $display("FAIL sign%0d_latency: got %0d want 10", i, lat); end
         checks++; if (resultado !== tq[i]) begin errors++; $display("FAIL sign%0d_resultado: got %h want %h", i, resultado, tq[i]); end
         checks++; if (resto !== tr[i]) begin errors++; $display("FAIL sign%0d_resto: got %h want %h", i, resto, tr[i]); end
      end
   endtask

   task automatic test_overflow();
      int lat, bc;
      do_op(8'h80, 8'hFF, lat, bc);
      checks++; if (lat !== 10) begin errors++; $display("FAIL ovf_latency: got %0d want 10", lat); end
      checks++; if (resultado !== 8'h80) begin errors++; $display("FAIL ovf_resultado: got %h want 80", resultado); end
      checks++; if (resto !== 8'h00) begin errors++; $display("FAIL ovf_resto: got %h want 00", resto); end
      checks++; if (flag_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", flag_overflow); end
      checks++; if (flag_div_zero !== 1'b0) begin errors++; $display("FAIL ovf_dz: got %b want 0", flag_div_zero); end
   endtask

   task automatic test_div_zero();
      int lat, bc;
      do_op(8'd5, 8'd0, lat, bc);
      checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
      checks++; if (bc !== 0 || busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got cycles=%0d busy=%b want 0", bc, busy); end
      checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL dz_resultado: got %h want 00", resultado); end
      checks++; if (resto !== 8'd5) begin errors++; $display("FAIL dz_resto: got %h want 05", resto); end
      checks++; if ({flag_overflow, flag_div_zero} !== 2'b01) begin errors++; $display("FAIL dz_flags: got %b want 01", {flag_overflow, flag_div_zero}); end
   endtask

   task automatic test_boundary();
      int lat, bc;
      do_op(8'h80, 8'd1, lat, bc);
      checks++; if (resultado !== 8'h80) begin errors++; $display("FAIL bnd_min_resultado: got %h want 80", resultado); end
      checks++; if (resto !== 8'h00) begin errors++; $display("FAIL bnd_min_resto: got %h want 00", resto); end
      checks++; if ({flag_overflow, flag_div_zero} !== 2'b00) begin errors++; $display("FAIL bnd_min_flags: got %b want 00", {flag_overflow, flag_div_zero}); end
      do_op(8'd5, 8'd9, lat, bc);
      checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL bnd_small_resultado: got %h want 00", resultado); end
      checks++; if (resto !== 8'd5) begin errors++; $display("FAIL bnd_small_resto: got %h want 05", resto); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0, first = 0, second = 0, both = 0;
      @(posedge clk); #1;
      a = 8'd100; b = 8'd7; start = 1'b1;
      for (int i = 1; i <= 22; i++) begin
         @(posedge clk); #1;
         if (busy === 1'b1 && done === 1'b1) both++;
         if (done === 1'b1) begin
            pulses++;
            if (first == 0) first = i; else second = i;
         end
      end
      start = 1'b0;
      checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
      checks++; if (first !== 10 || second !== 21) begin errors++; $display("FAIL b2b_timing: got %0d,%0d want 10,21", first, second); end
      checks++; if (both !== 0) begin errors++; $display("FAIL b2b_busy_and_done: got %0d want 0", both); end
      checks++; if ({resultado, resto} !== {8'd14, 8'd2}) begin errors++; $display("FAIL b2b_result: got %h want 0e02", {resultado, resto}); end
   endtask

   task automatic test_reset_mid();
      int lat, bc, dones = 0;
      @(posedge clk); #1;
      a = 8'h80; b = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, done, flag_overflow, flag_div_zero} !== 4'b0000) begin errors++; $display("FAIL mid_ctrl_cleared: got %b want 0000", {busy, done, flag_overflow, flag_div_zero}); end
      checks++; if ({resultado, resto} !== 16'h0000) begin errors++; $display("FAIL mid_data_cleared: got %h want 0000", {resultado, resto}); end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d active cycles want 0", dones); end
      do_op(8'd21, 8'd4, lat, bc);
      checks++; if (lat !== 10) begin errors++; $display("FAIL after_latency: got %0d want 10", lat); end
      checks++; if ({resultado, resto} !== {8'd5, 8'd1}) begin errors++; $display("FAIL after_result: got %h want 0501", {resultado, resto}); end
   endtask

   initial begin
      test_reset();
      test_positive();
      test_signs();
      test_overflow();
      test_div_zero();
      test_boundary();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mod_div.md
Name: mod_div

Overview:
- Signed iterative integer divider; the inverse companion to the 8-bit signed multiplier in the determinant arithmetic path.
- Computes quotient and remainder of two signed WIDTH-bit operands using restoring division on magnitudes, one quotient bit per clock.
- Uses a start/done handshake so the coprocessor control FSM can issue a divide and wait for the result.
- Flags divide-by-zero and the single unrepresentable case (most-negative / -1).

Parameters:
- WIDTH, 8, operand/result width in bits (two's complement); must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  signed dividend; captured on the accepting edge.
- b  input  WIDTH  signed divisor; captured on the accepting edge.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- resultado  output  WIDTH  signed quotient, truncated toward zero.
- resto  output  WIDTH  signed remainder; same sign as the dividend, or zero.
- flag_overflow  output  1  quotient not representable.
- flag_div_zero  output  1  divisor was zero.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, resultado, resto, flag_overflow and flag_div_zero all 0; internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 with b!=0: latch |a| and |b| as unsigned WIDTH bits (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits), latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB], clear the iteration counter, go to CALC, busy=1.
  - start=1 with b==0: go directly to DONE with resultado=0, resto=a, flag_div_zero=1, flag_overflow=0.
- CALC: exactly WIDTH cycles.
  - Each cycle: shift {partial remainder, dividend} left by one, trial-subtract the divisor magnitude, keep the difference if it is non-negative, shift in quotient bit 1/0.
  - Counter runs 0..WIDTH-1; at WIDTH-1 go to FIX.
- FIX (1 cycle):
  - Negate the quotient magnitude if sign_q=1; negate the remainder magnitude if sign_r=1.
  - Register resultado and resto.
  - flag_overflow=1 if and only if a = -2^(WIDTH-1) and b = -1; in that case resultado = -2^(WIDTH-1) (wrapped) and resto = 0.
  - flag_div_zero=0. Go to DONE.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- Latency, counted from the edge that samples start:
  - Normal case: done is high in the cycle after edge WIDTH+2 (10 cycles for WIDTH=8).
  - Divide-by-zero case: done is high after edge 1.
- start is ignored while busy or done=1; there is no queuing.
- resultado, resto and both flags hold their values until the next accepted start updates them. They are not cleared on accept; they change only in FIX or DONE.
- done and busy are never high in the same cycle.

Decomposition:
- Package mod_div_pkg:
  - state enum (IDLE, CALC, FIX, DONE);
  - default WIDTH constant;
  - helper function for two's-complement magnitude and negate.
- One combinational sub-module mod_div_step performs a single restoring iteration: inputs partial remainder, next dividend bit, divisor; outputs new remainder and quotient bit.
- The top level holds the FSM, counter and operand registers.

Test Plan:
- Positive operands: a=100, b=7, start pulse -> done after 10 cycles, resultado=14, resto=2, both flags 0; busy high for the 9 cycles before done.
- Sign combinations:
  - a=-100, b=7 -> resultado=-14, resto=-2.
  - a=100, b=-7 -> resultado=-14, resto=2.
  - a=-100, b=-7 -> resultado=14, resto=-2.
- Overflow corner: a=-128, b=-1 -> resultado=-128, resto=0, flag_overflow=1.
- Boundary cases:
  - a=-128, b=1 -> resultado=-128, flag_overflow=0.
  - a=5, b=9 -> resultado=0, resto=5.
- Divide by zero: a=5, b=0 -> done 1 cycle after accept, resultado=0, resto=5, flag_div_zero=1, busy never high.
- Control robustness:
  - start held high throughout an operation -> exactly one result per accept, with back-to-back operations separated by the DONE cycle.
  - rst_n low during CALC -> all outputs 0, no done pulse.
  - A subsequent a=21, b=4 returns resultado=5, resto=1.
